// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/halfword/word loads and stores into aligned word accesses,
// using read-modify-write for sub-word stores.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, WR, DONE} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, merge_q, shifted, mask, merged, load_val;
  logic [1:0]  size_q;
  logic        sign_ext_q, err_q, err;
  logic [4:0]  sh;
  assign err = (size == 2'b11) | ((size == 2'b01) & addr[0]) | ((size == 2'b10) & |addr[1:0]);
  assign sh = {addr_q[1:0], 3'b000};
  assign shifted = mem_rdata >> sh;
  assign load_val = (size_q == 2'b00) ? {{24{sign_ext_q & shifted[7]}}, shifted[7:0]} :
                    (size_q == 2'b01) ? {{16{sign_ext_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
  assign mask = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (merge_q & ~mask) | ((wdata_q << sh) & mask);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign misaligned = done & err_q;
  assign mem_read = (state == LOAD) | (state == RMW_RD);
  assign mem_write = (state == RMW_WR) | (state == WR);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wdata = (state == WR) ? wdata_q : (state == RMW_WR) ? merged : 32'h0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      size_q <= '0;
      sign_ext_q <= 1'b0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        addr_q <= addr;
        wdata_q <= wdata;
        size_q <= size;
        sign_ext_q <= sign_ext;
        err_q <= err;
      end
      if (state == LOAD) rdata <= load_val;
      if (state == RMW_RD) merge_q <= mem_rdata;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = !req ? IDLE : err ? DONE : !we ? LOAD : (size == 2'b10) ? WR : RMW_RD;
      RMW_RD: state_n = RMW_WR;
      LOAD, RMW_WR, WR: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit with a word memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, misaligned, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_d = '0;
  int checks = 0, errors = 0, cyc = 0, acc = 0, seq = 0;

  typedef struct {
    logic we; logic [1:0] size; logic sx; logic [31:0] addr, wdata, rd;
    logic mis; int lat, seq; logic [5:0] idx; logic [31:0] mw;
  } vec_t;
  vec_t q[$];
  vec_t tv[14];
  vec_t e;

  load_store_unit dut (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_d;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, x);
    end
  endtask

  // Read/write activity is folded into seq so order and count are checked together.
  always @(negedge clk) begin
    if (!rst_n) seq = 0;
    else begin
      if (mem_read || mem_write) chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (mem_read) seq = seq * 4 + 1;
      if (mem_write) seq = seq * 4 + 2;
      if (!done) chk("misaligned_without_done", {31'b0, misaligned}, 32'h0);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
        else begin
          e = q.pop_front();
          chk("rdata", rdata, e.rd);
          chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
          chk("latency", cyc - acc + 1, e.lat);
          chk("mem_access_seq", seq, e.seq);
          chk("mem_word", mem[e.idx], e.mw);
        end
        seq = 0;
      end
    end
  end

  task automatic preload(input logic [5:0] i, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = i; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'h1, 32'h0);
      q.delete();
    end
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    acc = cyc;
    q.push_back(v);
    req = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    //        we    size  sx    addr    wdata         rd            mis  lat seq idx    mem word
    tv[0]  = '{1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[1]  = '{1'b0, 2'd0, 1'b0, 32'h40, 32'h0,        32'h0000007F, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[2]  = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[3]  = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        32'h00008001, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[4]  = '{1'b1, 2'd0, 1'b0, 32'h82, 32'hFFFFFFAB, 32'h00008001, 1'b0, 3, 6, 6'h20, 32'h11AB3344};
    tv[5]  = '{1'b1, 2'd1, 1'b0, 32'h80, 32'h1234BEEF, 32'h00008001, 1'b0, 3, 6, 6'h20, 32'h11ABBEEF};
    tv[6]  = '{1'b1, 2'd2, 1'b0, 32'h84, 32'hDEADBEEF, 32'h00008001, 1'b0, 2, 2, 6'h21, 32'hDEADBEEF};
    tv[7]  = '{1'b0, 2'd2, 1'b1, 32'h84, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 6'h21, 32'hDEADBEEF};
    tv[8]  = '{1'b0, 2'd1, 1'b1, 32'h41, 32'h0,        32'hDEADBEEF, 1'b1, 1, 0, 6'h10, 32'h8001FF7F};
    tv[9]  = '{1'b1, 2'd2, 1'b0, 32'h86, 32'h0,        32'hDEADBEEF, 1'b1, 1, 0, 6'h21, 32'hDEADBEEF};
    tv[10] = '{1'b0, 2'd3, 1'b0, 32'h80, 32'h0,        32'hDEADBEEF, 1'b1, 1, 0, 6'h20, 32'h11ABBEEF};
    tv[11] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h8001FF7F, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[12] = '{1'b0, 2'd0, 1'b1, 32'h40, 32'h0,        32'h0000007F, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    tv[13] = '{1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        32'hFFFFFF7F, 1'b0, 2, 1, 6'h10, 32'h8001FF7F};
    preload(6'h00, 32'h0);
    preload(6'h10, 32'h8001FF7F);
    preload(6'h20, 32'h11223344);
    preload(6'h21, 32'h0);
    preload(6'h22, 32'h55667788);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) run(tv[i]);

    // Reset during RMW_WR: write must vanish at once and the word stays intact.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h88; wdata = 32'hAA;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmw_wr_active", {31'b0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write", {31'b0, mem_write}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_word_intact", mem[6'h22], 32'h55667788);
    chk("reset_rdata_cleared", rdata, 32'h0);
    chk("reset_idle", {31'b0, busy}, 32'h0);
    run('{1'b0, 2'd0, 1'b0, 32'h89, 32'h0, 32'h00000077, 1'b0, 2, 1, 6'h22, 32'h55667788});

    // A store request pulsed while a load is busy must be ignored.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h88; wdata = 32'h0;
    @(posedge clk); #1;
    acc = cyc;
    q.push_back('{1'b0, 2'd2, 1'b0, 32'h88, 32'h0, 32'h55667788, 1'b0, 2, 1, 6'h22, 32'h55667788});
    we = 1'b1; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("busy_req_ignored_mem", mem[6'h22], 32'h55667788);
    chk("busy_req_ignored_idle", {31'b0, busy}, 32'h0);
    chk("scoreboard_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
